psram_qpi_responder: RTL
========================

# psram_qpi_responder

Synthesizable responder for the quad-SPI PSRAM bus: the device end of the link driven by the memory controller. Used as an FPGA bring-up target and as the RAM model in controller benches. It oversamples the controller's serial clock on `clkRAM`, decodes the command set the controller issues, and backs it with an on-chip byte array. It powers up in SPI mode and switches to QPI on command 0x35.

## Interface
Parameters:
- `ADDR_W`, 16 — implemented address bits; the 24-bit bus address is truncated to its low `ADDR_W` bits.
- `WAIT_CYCLES`, 6 — dummy sclk rising edges between the last read-address nibble and the first data nibble.

Ports (clock and reset first):
- `clkRAM`  in  1  oversampling clock; one clock domain; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `i_psram_cs`  in  1  chip select, active low.
- `i_psram_sclk`  in  1  serial clock from the controller; asynchronous to `clkRAM`.
- `i_psram_sio`  in  4  SIO[3:0] as driven by the controller.
- `o_psram_sio`  out  4  read data nibble.
- `o_psram_sio_oe`  out  1  output enable; high only during read data.
- `o_qpiMode`  out  1  1 = QPI mode is active.
- `o_cmdError`  out  1  one-cycle pulse when an unsupported opcode is decoded.

## Operation
- **Input synchronization:** cs, sclk and sio are each synchronized through 2 flops. sclk rise/fall is detected from the synchronized copy; sio is sampled on a detected rise.
- **Reset values:** state IDLE, `o_qpiMode` 0, `o_psram_sio` 0, `o_psram_sio_oe` 0, `o_cmdError` 0. Memory contents are not reset.
- **Command phase:**
  - SPI mode: 8 rises on sio[0], MSB first.
  - QPI mode: 2 rises on sio[3:0], high nibble first.
- **Opcodes:**
  - 0x35: enter QPI.
  - 0xF5: exit QPI (QPI mode only).
  - 0x38: quad write.
  - 0xEB: quad read.
  - 0x35 received in QPI mode is a no-op.
  - Any other opcode: pulse `o_cmdError`, go to IGNORE until cs rises.
- **Address phase:** after 0x38/0xEB, 6 quad nibbles (A23..A0, high first) in either mode.
- **Write (0x38):** data nibbles, high nibble first. Each completed byte is written to mem[addr], then addr increments. A partial byte at cs rise is discarded.
- **Read (0xEB):** count `WAIT_CYCLES` rises after the address phase, then present the data nibbles of mem[addr], high nibble first. addr increments after each low nibble.
- **Address wrap:** addr wraps modulo 2^`ADDR_W` for both reads and writes.
- **States:** IDLE → CMD → {ADDR → (WDATA | WAIT → RDATA)} | IGNORE.
- **cs deasserted:** synchronized cs high in any state → IDLE, `o_psram_sio_oe` 0, bit/nibble counters cleared.
- **cs fall:** from IDLE, CMD starts on the first rise after synchronized cs falls.
- **Reset mid-transfer:** immediate return to reset values. The partial byte is not written. QPI mode is lost.

## Timing
- Each sclk high and low phase must last ≥ 3 `clkRAM` periods. Input-to-detection latency is 2 cycles plus 1 cycle for the edge register.
- Read drive:
  - `o_psram_sio` / `o_psram_sio_oe` update one `clkRAM` cycle after a detected sclk fall.
  - The first data nibble is driven on the fall following the `WAIT_CYCLES`-th dummy rise. Data is stable before the next controller rise.
- Memory write commits one `clkRAM` cycle after the rise that samples the low nibble.
- A read of address N immediately after a write to N in the same session returns the new data.
- `o_cmdError` is high exactly 1 cycle, on the cycle after the 8th command bit is sampled.

## Structure
- `psram_pkg`:
  - opcode constants `CMD_ENTER_QPI`, `CMD_EXIT_QPI`, `CMD_WRITE`, `CMD_READ`
  - state enum
  - address width 24 constant
- Sub-module `psram_sync_edge`: 2-flop synchronizer plus rise/fall detector. Instantiated for sclk and cs; sio uses the synchronizer only.
- Memory is an inferred single-port byte array in the top module.

## Test plan
- Reset asserted mid-session → all outputs 0, state IDLE, `o_qpiMode` 0. Next SPI 0x35 (8 rises, cs low) → `o_qpiMode`=1 after cs rises.
- QPI 0x38, address 0x00C000, data 0xAA → a subsequent QPI 0xEB at 0x00C000 drives nibbles 0xA, 0xA on the 7th and 8th falls after the address.
- Burst write 0x11,0x22,0x33 at 0x00FFFF (`ADDR_W`=16), then read 3 bytes at 0x00FFFF → 0x11,0x22,0x33, proving the wrap to 0x0000.
- Opcode 0x5A in QPI → `o_cmdError` pulses once. Subsequent nibbles are ignored, `o_psram_sio_oe` stays 0, and memory is unchanged.
- cs raised after 1 write nibble → the byte is not written, and the next 0xEB at the same address returns the prior contents.
- QPI 0xF5 → `o_qpiMode`=0. Then a QPI-formatted command is treated as SPI bits, and SPI 0x38 works again.

Source files
------------

// File: rtl/psram_qpi_responder_pkg.sv
// Shared opcodes, FSM state encoding and command-shift helper for the PSRAM
// QPI responder.
package psram_pkg;

  localparam int BUS_ADDR_W = 24;

  localparam logic [7:0] CMD_ENTER_QPI = 8'h35;
  localparam logic [7:0] CMD_EXIT_QPI  = 8'hF5;
  localparam logic [7:0] CMD_WRITE     = 8'h38;
  localparam logic [7:0] CMD_READ      = 8'hEB;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_WDATA  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_RDATA  = 3'd5,
    ST_IGNORE = 3'd6
  } state_t;

  // Opcode accumulator: one bit per rise in SPI mode, one nibble in QPI mode.
  function automatic logic [7:0] shift_cmd(input logic [6:0] cur,
                                           input logic [3:0] sio,
                                           input logic       qpi);
    return qpi ? {cur[3:0], sio} : {cur, sio[0]};
  endfunction

endpackage

// File: rtl/psram_qpi_responder_sync_edge.sv
// Two-flop synchronizer for one asynchronous input plus registered
// rise/fall pulses derived from the synchronized level.
module psram_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
      prev <= RST_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
      prev <= q;
      rise <= q & ~prev;
      fall <= ~q & prev;
    end
  end

endmodule

// File: rtl/psram_qpi_responder.sv
// Device end of the quad-SPI PSRAM link: oversamples the controller's sclk,
// decodes SPI/QPI commands and serves quad reads/writes from an on-chip array.
module psram_qpi_responder #(
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 6
) (
  input  logic       clkRAM,
  input  logic       reset,
  input  logic       i_psram_cs,
  input  logic       i_psram_sclk,
  input  logic [3:0] i_psram_sio,
  output logic [3:0] o_psram_sio,
  output logic       o_psram_sio_oe,
  output logic       o_qpiMode,
  output logic       o_cmdError
);
  import psram_pkg::*;

  localparam int         WC_W      = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [2:0] ADDR_LAST = 3'(BUS_ADDR_W / 4 - 1);

  state_t          state, state_next;
  logic            cs_q, cs_rise, cs_fall;
  logic            sclk_q, sclk_rise, sclk_fall;
  logic [3:0]      sio_meta, sio_s;
  logic            deselect, rise_ev, fall_ev;
  logic            cmd_last, addr_last, wait_last, mem_we;
  logic [7:0]      cmd_byte, rd_byte;
  logic [6:0]      cmd_sh;
  logic [2:0]      bit_cnt, nib_cnt;
  logic [WC_W-1:0] wait_cnt;
  logic [ADDR_W-1:0] addr;
  logic            hi_half, is_read;
  logic [3:0]      wr_hi, sio_next;
  logic            oe_next, qpi_next, err_next;
  logic [7:0]      mem [0:2**ADDR_W-1];

  psram_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk(clkRAM), .rst(reset), .d(i_psram_cs),
    .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );

  psram_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk(clkRAM), .rst(reset), .d(i_psram_sclk),
    .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );

  always_ff @(posedge clkRAM or posedge reset) begin
    if (reset) begin
      sio_meta <= 4'h0;
      sio_s    <= 4'h0;
    end else begin
      sio_meta <= i_psram_sio;
      sio_s    <= sio_meta;
    end
  end

  // An edge only counts if the level still agrees a cycle later (glitch reject).
  assign deselect  = cs_q | cs_rise;
  assign rise_ev   = sclk_rise & sclk_q;
  assign fall_ev   = sclk_fall & ~sclk_q;
  assign cmd_byte  = shift_cmd(cmd_sh, sio_s, o_qpiMode);
  assign cmd_last  = rise_ev & (bit_cnt == (o_qpiMode ? 3'd1 : 3'd7));
  assign addr_last = rise_ev & (nib_cnt == ADDR_LAST);
  assign wait_last = rise_ev & (wait_cnt == WC_W'(WAIT_CYCLES - 1));
  assign rd_byte   = mem[addr];

  always_ff @(posedge clkRAM or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (deselect) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (cs_fall) state_next = ST_CMD; else state_next = ST_IDLE;
        ST_CMD: begin
          if (cmd_last) begin
            if (cmd_byte == CMD_WRITE || cmd_byte == CMD_READ) state_next = ST_ADDR;
            else                                                 state_next = ST_IGNORE;
          end else begin
            state_next = ST_CMD;
          end
        end
        ST_ADDR: begin
          if (addr_last) begin
            if (is_read) state_next = (WAIT_CYCLES == 0) ? ST_RDATA : ST_WAIT;
            else         state_next = ST_WDATA;
          end else begin
            state_next = ST_ADDR;
          end
        end
        ST_WAIT:   if (wait_last) state_next = ST_RDATA; else state_next = ST_WAIT;
        ST_WDATA:  state_next = ST_WDATA;
        ST_RDATA:  state_next = ST_RDATA;
        ST_IGNORE: state_next = ST_IGNORE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    sio_next = o_psram_sio;
    oe_next  = o_psram_sio_oe;
    qpi_next = o_qpiMode;
    err_next = 1'b0;
    mem_we   = 1'b0;
    if (deselect) begin
      oe_next = 1'b0;
    end else begin
      case (state)
        ST_CMD: begin
          if (cmd_last) begin
            case (cmd_byte)
              CMD_ENTER_QPI: qpi_next = 1'b1;
              CMD_EXIT_QPI: begin
                if (o_qpiMode) qpi_next = 1'b0;
                else           err_next = 1'b1;
              end
              CMD_WRITE, CMD_READ: err_next = 1'b0;
              default:             err_next = 1'b1;
            endcase
          end else begin
            err_next = 1'b0;
          end
        end
        ST_WDATA: mem_we = rise_ev & hi_half;
        ST_RDATA: begin
          if (fall_ev) begin
            oe_next  = 1'b1;
            sio_next = hi_half ? rd_byte[3:0] : rd_byte[7:4];
          end else begin
            oe_next  = o_psram_sio_oe;
          end
        end
        default: oe_next = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clkRAM or posedge reset) begin
    if (reset) begin
      o_psram_sio    <= 4'h0;
      o_psram_sio_oe <= 1'b0;
      o_qpiMode      <= 1'b0;
      o_cmdError     <= 1'b0;
    end else begin
      o_psram_sio    <= sio_next;
      o_psram_sio_oe <= oe_next;
      o_qpiMode      <= qpi_next;
      o_cmdError     <= err_next;
    end
  end

  // Counters, address pointer and nibble staging; addr doubles as the address shifter.
  always_ff @(posedge clkRAM or posedge reset) begin
    if (reset) begin
      cmd_sh   <= 7'h00;
      bit_cnt  <= 3'd0;
      nib_cnt  <= 3'd0;
      wait_cnt <= '0;
      addr     <= '0;
      hi_half  <= 1'b0;
      is_read  <= 1'b0;
      wr_hi    <= 4'h0;
    end else if (deselect || state == ST_IDLE) begin
      cmd_sh   <= 7'h00;
      bit_cnt  <= 3'd0;
      nib_cnt  <= 3'd0;
      wait_cnt <= '0;
      hi_half  <= 1'b0;
    end else begin
      case (state)
        ST_CMD: begin
          if (rise_ev) begin
            cmd_sh  <= cmd_byte[6:0];
            bit_cnt <= cmd_last ? 3'd0 : bit_cnt + 3'd1;
            if (cmd_last) is_read <= (cmd_byte == CMD_READ);
          end
        end
        ST_ADDR: begin
          if (rise_ev) begin
            addr    <= {addr[ADDR_W-5:0], sio_s};
            nib_cnt <= addr_last ? 3'd0 : nib_cnt + 3'd1;
            hi_half <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (rise_ev) wait_cnt <= wait_cnt + WC_W'(1);
        end
        ST_WDATA: begin
          if (rise_ev) begin
            hi_half <= ~hi_half;
            if (hi_half) addr  <= addr + ADDR_W'(1);
            else         wr_hi <= sio_s;
          end
        end
        ST_RDATA: begin
          if (fall_ev) begin
            hi_half <= ~hi_half;
            if (hi_half) addr <= addr + ADDR_W'(1);
          end
        end
        default: hi_half <= hi_half;
      endcase
    end
  end

  always_ff @(posedge clkRAM) begin
    if (mem_we) mem[addr] <= {wr_hi, sio_s};
  end

endmodule
